fpu_norm_sched: RTL
===================

# fpu_norm_sched

Round-robin scheduler that shares one `fpu_normalize` instance between `NREQ` FPU requesters, for example the add/sub and multiply back-ends. Each requester hands over an unnormalized sign/exponent/extended-fraction triple through a valid/ready handshake. The scheduler pulses the normalizer's `start`, waits for `busy` to fall, and returns the packed result to the owning requester through a per-requester valid/ready response. A watchdog flags a normalizer that never completes.

## Interface
- `WIDTH`, default `fpu_p::FPU_32`: total float width.
- `E`, default `fpu_p::FPU_32_E`: exponent width.
- `F`, default `fpu_p::FPU_32_F`: stored fraction width. Extended fraction width is `W = F + fpu_p::FPU_OFFSET + 1`.
- `NREQ`, default 2: number of requesters, 2..8.
- `clk  in  1`: the single clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `req_valid  in  NREQ`: per-requester operand valid.
- `req_ready  out  NREQ`: one-hot accept, combinational.
- `req_sign  in  NREQ`: per-requester sign.
- `req_exp  in  NREQ×E`: per-requester exponent.
- `req_frac  in  NREQ×W`: per-requester extended fraction.
- `rsp_valid  out  NREQ`: one-hot result valid to the owner.
- `rsp_ready  in  NREQ`: per-requester result accept.
- `rsp_s  out  1`: result sign.
- `rsp_e  out  E`: result exponent.
- `rsp_f  out  F`: result fraction.
- `rsp_err  out  1`: watchdog fired; result fields are 0.
- `norm_start  out  1`: start pulse to the normalizer.
- `norm_sign  out  1`: operand sign to the normalizer.
- `norm_exp  out  E`: operand exponent to the normalizer.
- `norm_frac  out  W`: operand fraction to the normalizer.
- `norm_busy  in  1`: normalizer `busy`. It is high during the start cycle.
- `norm_s  in  1`: normalizer result sign.
- `norm_e  in  E`: normalizer result exponent.
- `norm_f  in  F`: normalizer result fraction.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- FSM `fpu_p::SchedState` has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant goes to the first `i` with `req_valid[i]`, searching from `rr_ptr` upward modulo `NREQ`.
  - `req_ready[i]` is 1 only for the granted index, and only in IDLE.
  - On handshake: register the operands into `norm_*`, set `owner <= i`, set `rr_ptr <= (i+1) mod NREQ`, go to ISSUE.
- **ISSUE**
  - `norm_start = 1` for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
  - `norm_busy` is ignored in this cycle.
- **WAIT**
  - The counter increments every cycle.
  - When `norm_busy == 0`: latch `norm_s/e/f` into `rsp_*`, set `rsp_err = 0`, go to RESP.
  - When the counter reaches `LIMIT = W + 3` with `norm_busy` still 1: set `rsp_s/e/f = 0`, set `rsp_err = 1`, go to RESP.
- **RESP**
  - `rsp_valid[owner] = 1`; `rsp_*` are held stable.
  - On `rsp_ready[owner]`: go to IDLE with `rsp_valid = 0`.
  - `rsp_ready` of non-owners is ignored.
- `norm_sign/exp/frac` hold their last values outside ISSUE. They change only on the IDLE accept.
- The normalizer exits early when the fraction is 0 or the exponent is 0.
  - Shift count is `k = min(leading zeros of frac, exp)`, or 0 if `frac == 0`.
  - The scheduler does not compute `k`; it only waits for `busy` to fall.
- **Reset, including mid-operation:** all state clears immediately.
  - State = IDLE, `rr_ptr = 0`, `owner = 0`.
  - `norm_start`, `rsp_valid`, `rsp_*`, `rsp_err`, `norm_*`, `busy` are all 0.
  - `req_ready = 0` while `rst_n` is low.
  - At top level the normalizer's `rst` is tied to `~rst_n`, so both restart together. An in-flight result is discarded and never presented.

## Timing
- Accept handshake in cycle 0, `norm_start` in cycle 1, normalizer BUSY from cycle 2.
- `rsp_valid` rises in cycle `4 + k`. Minimum latency is 4 cycles.
- Throughput is one operation per `5 + k` cycles when `rsp_ready` is held high. The next accept happens no earlier than the cycle after the RESP handshake.
- A requester whose valid is asserted while another request is in flight waits. Round-robin bounds that wait to `NREQ - 1` other operations.
- Simultaneous valids in IDLE: exactly one `req_ready` bit is set, per `rr_ptr`.
- Watchdog response appears at cycle `2 + LIMIT + 1`.

## Structure
- Add to `fpu_p`:
  - the `SchedState` enum (IDLE, ISSUE, WAIT, RESP);
  - the constant `FPU_NORM_WD_MARGIN = 3`.
- Reuse `fpu_p::FPU_32*` and `fpu_p::FPU_OFFSET` for widths.
- Sub-module `fpu_rr_arbiter` is combinational: inputs valid and ptr, output one-hot grant and index. It is reused later by other shared FPU units.
- The scheduler does not instantiate `fpu_normalize`; the wrapper connects them.

## Test plan
- **Single, already normalized:** NREQ=2, req0 with `frac = 1<<(W-1)`, `exp = 8'h80`, sign 1 → `rsp_valid[0]` at cycle 4, `rsp_e = 8'h80`, `rsp_s = 1`, `rsp_err = 0`.
- **Shift by 3:** req1 with `frac = 1<<(W-4)`, `exp = 8'h80` → `rsp_valid[1]` at cycle 7, `rsp_e = 8'h7D`, `rsp_f` MSB = 1.
- **Exponent clamp and zero fraction:**
  - `frac = 1`, `exp = 2` → cycle 6, `rsp_e = 0`, and `rsp_f` equals `(1<<2)` truncated to its top `F` bits.
  - `frac = 0`, `exp = 8'h55` → cycle 4, `rsp_e = 8'h55`.
- **Arbitration:** req0 and req1 held valid continuously with `rsp_ready = 1` → grants alternate 0,1,0,1 and no requester is granted twice in a row.
- **Backpressure:** `rsp_ready[0]` held low for 10 cycles → `rsp_valid[0]` and `rsp_*` stay stable, `req_ready` stays 0, and the operation completes on release.
- **Fault and reset:**
  - `norm_busy` forced high → `rsp_err = 1` at cycle `W + 6`, with result fields 0.
  - Separately, deassert `rst_n` during WAIT → all outputs become 0 asynchronously, no `rsp_valid` appears, and the next request after reset is granted to req0.

Source files
------------

// File: rtl/fpu_norm_sched_pkg.sv
// Shared FPU definitions: float widths, scheduler state encoding and watchdog margin.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fpu_p;

  localparam int FPU_32             = 32;
  localparam int FPU_32_E           = 8;
  localparam int FPU_32_F           = 23;
  // Guard/round/sticky bits carried below the stored fraction.
  localparam int FPU_OFFSET         = 3;
  // Extra cycles beyond the worst-case shift before the watchdog gives up.
  localparam int FPU_NORM_WD_MARGIN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } SchedState;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or after i_ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: i_valid (N requests), i_ptr (search start) -> o_grant (one-hot), o_idx (binary), o_any.
module fpu_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int i = 0; i < N; i++) begin
      // The pointer is always < N, so a single subtraction wraps the offset.
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_valid[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fpu_norm_sched.sv
// Shares one normalizer between NREQ requesters: accept, pulse start, wait for busy to fall, return result.
// Latency: result valid 4+k cycles after accept (k = normalizer shift); watchdog result at LIMIT+3.
// Backpressure: req_ready only in IDLE; result held in RESP until the owner's rsp_ready.
// Ports: req_* (per-requester operand handshake), rsp_* (result to owner), norm_* (normalizer side), busy.
module fpu_norm_sched
  import fpu_p::*;
#(
  parameter int WIDTH = FPU_32,
  parameter int E     = FPU_32_E,
  parameter int F     = FPU_32_F,
  parameter int NREQ  = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0]                     req_sign,
  input  logic [NREQ*E-1:0]                   req_exp,
  input  logic [NREQ*(F+FPU_OFFSET+1)-1:0]    req_frac,
  output logic [NREQ-1:0]                     rsp_valid,
  input  logic [NREQ-1:0]                     rsp_ready,
  output logic                                rsp_s,
  output logic [E-1:0]                        rsp_e,
  output logic [F-1:0]                        rsp_f,
  output logic                                rsp_err,
  output logic                                norm_start,
  output logic                                norm_sign,
  output logic [E-1:0]                        norm_exp,
  output logic [F+FPU_OFFSET:0]               norm_frac,
  input  logic                                norm_busy,
  input  logic                                norm_s,
  input  logic [E-1:0]                        norm_e,
  input  logic [F-1:0]                        norm_f,
  output logic                                busy
);

  localparam int W     = F + FPU_OFFSET + 1;
  localparam int LIMIT = W + FPU_NORM_WD_MARGIN;
  localparam int CW    = $clog2(LIMIT + 1);
  localparam int IW    = $clog2(NREQ);

  if (WIDTH != 1 + E + F) begin : g_width_chk
    $error("fpu_norm_sched: WIDTH must equal 1 + E + F");
  end

  SchedState       r_state, w_next_state;
  logic [IW-1:0]   r_rr_ptr, r_owner;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic            w_wd_fire;

  fpu_rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_wd_fire  = (r_cnt >= CW'(LIMIT));
  assign norm_start = (r_state == ISSUE);
  assign busy       = (r_state != IDLE);

  // The rst_n gate keeps req_ready low during reset even though the arbiter is combinational.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (r_state == IDLE && rst_n) req_ready = w_grant;
    if (r_state == RESP)          rsp_valid[r_owner] = 1'b1;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (!norm_busy || w_wd_fire) w_next_state = RESP;
      RESP:    if (rsp_ready[r_owner]) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      norm_sign <= 1'b0;
      norm_exp  <= '0;
      norm_frac <= '0;
      rsp_s     <= 1'b0;
      rsp_e     <= '0;
      rsp_f     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          norm_sign <= req_sign[w_gidx];
          norm_exp  <= req_exp[w_gidx*E +: E];
          norm_frac <= req_frac[w_gidx*W +: W];
          r_owner   <= w_gidx;
          r_rr_ptr  <= (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A normal completion wins over a watchdog expiry in the same cycle.
          if (!norm_busy) begin
            rsp_s   <= norm_s;
            rsp_e   <= norm_e;
            rsp_f   <= norm_f;
            rsp_err <= 1'b0;
          end else if (w_wd_fire) begin
            rsp_s   <= 1'b0;
            rsp_e   <= '0;
            rsp_f   <= '0;
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
